// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read address/data ports, two write ports and the ready flag.
// master = datapath side driving addresses/writes, slave = the register file.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     ready;
  logic [NUM_RD*ADDR_W-1:0] readReg;
  logic [NUM_RD*DATA_W-1:0] readData;
  logic [ADDR_W-1:0]        writeReg0;
  logic [DATA_W-1:0]        writeData0;
  logic                     writeEnable0;
  logic [ADDR_W-1:0]        writeReg1;
  logic [DATA_W-1:0]        writeData1;
  logic                     writeEnable1;

  modport master (
    input  ready, readData,
    output readReg, writeReg0, writeData0, writeEnable0,
           writeReg1, writeData1, writeEnable1
  );

  modport slave (
    output ready, readData,
    input  readReg, writeReg0, writeData0, writeEnable0,
           writeReg1, writeData1, writeEnable1
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with post-reset sequential clear and dual write ports.
// Optional macro RF_BYPASS_EN forwards same-cycle write data to matching read ports.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              run;
  logic [ADDR_W-1:0] rd_addr [NUM_RD];
  logic [DATA_W-1:0] rd_val  [NUM_RD];
  logic              wr0_ok, wr1_ok;

  // Reset dominates combinationally so nothing is visible while rst is held.
  assign run       = (state_q == RUN) && !rst;
  assign bus.ready = run;

  assign wr0_ok = bus.writeEnable0 && !(ZERO_REG != 0 && bus.writeReg0 == '0);
  assign wr1_ok = bus.writeEnable1 && !(ZERO_REG != 0 && bus.writeReg1 == '0);

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    mem_d     = mem_q;
    if (rst) begin
      state_d   = CLEAR;
      clr_ptr_d = '0;
    end else if (state_q == CLEAR) begin
      mem_d[clr_ptr_q] = '0;
      clr_ptr_d        = clr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      if (clr_ptr_q == {ADDR_W{1'b1}}) state_d = RUN;
    end else begin
      // Port 1 is applied last so it wins an address collision.
      if (wr0_ok) mem_d[bus.writeReg0] = bus.writeData0;
      if (wr1_ok) mem_d[bus.writeReg1] = bus.writeData1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    bus.readData = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_addr[i] = bus.readReg[i*ADDR_W +: ADDR_W];
      rd_val[i]  = mem_q[rd_addr[i]];
`ifdef RF_BYPASS_EN
      if (bus.writeEnable1 && bus.writeReg1 == rd_addr[i])
        rd_val[i] = bus.writeData1;
      else if (bus.writeEnable0 && bus.writeReg0 == rd_addr[i])
        rd_val[i] = bus.writeData0;
`endif
      if (ZERO_REG != 0 && rd_addr[i] == '0) rd_val[i] = '0;
      if (run) bus.readData[i*DATA_W +: DATA_W] = rd_val[i];
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (DATA_W=32, ADDR_W=5, NUM_RD=2, ZERO_REG=1).
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.readReg = {a1, a0};
    #1;
  endtask

  task automatic wr(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                    input logic e1, input logic [4:0] a1, input logic [31:0] d1);
    bus.writeEnable0 = e0; bus.writeReg0 = a0; bus.writeData0 = d0;
    bus.writeEnable1 = e1; bus.writeReg1 = a1; bus.writeData1 = d1;
  endtask

  // Counts edges with ready low after rst falls; ready must rise right after edge 32.
  task automatic clear_seq(input string tag);
    for (int k = 1; k <= 32; k++) begin
      chk({tag, "_ready_low"}, {31'd0, bus.ready}, 32'd0);
      step();
    end
    chk({tag, "_ready_high"}, {31'd0, bus.ready}, 32'd1);
  endtask

  logic [31:0] byp_exp;

  initial begin
    rst = 1'b1;
    bus.readReg = '0;
    wr(0, 0, 0, 0, 0, 0);
    step();
    step();
    rd(5'd3, 5'd4);
    chk("rst_ready", {31'd0, bus.ready}, 32'd0);
    chk("rst_rd0", bus.readData[31:0], 32'd0);
    chk("rst_rd1", bus.readData[63:32], 32'd0);

    // Clear phase; a write to reg 7 after it was cleared must be dropped.
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      chk("clr_ready_low", {31'd0, bus.ready}, 32'd0);
      if (k == 20) wr(1, 5'd7, 32'hCAFEF00D, 0, 0, 0);
      else         wr(0, 0, 0, 0, 0, 0);
      if (k == 20) begin
        rd(5'd7, 5'd7);
        chk("clr_rd_zero", bus.readData[31:0], 32'd0);
      end
      step();
    end
    wr(0, 0, 0, 0, 0, 0);
    chk("clr_ready_high", {31'd0, bus.ready}, 32'd1);

    for (int i = 0; i < 32; i++) begin
      rd(i[4:0], i[4:0]);
      chk("post_clear_p0", bus.readData[31:0], 32'd0);
      chk("post_clear_p1", bus.readData[63:32], 32'd0);
    end
    rd(5'd7, 5'd7);
    chk("dropped_clear_write", bus.readData[31:0], 32'd0);

    // Basic write/read on both ports.
    wr(1, 5'd2, 32'h12345678, 0, 0, 0);
    step();
    wr(0, 0, 0, 0, 0, 0);
    rd(5'd2, 5'd2);
    chk("basic_p0", bus.readData[31:0], 32'h12345678);
    chk("basic_p1", bus.readData[63:32], 32'h12345678);
    rd(5'd3, 5'd2);
    chk("basic_reg3", bus.readData[31:0], 32'd0);

    // Collision: port 1 wins.
    wr(1, 5'd5, 32'hAAAA0000, 1, 5'd5, 32'h5555FFFF);
    step();
    wr(0, 0, 0, 0, 0, 0);
    rd(5'd5, 5'd2);
    chk("collision", bus.readData[31:0], 32'h5555FFFF);

    // Distinct addresses commit together.
    wr(1, 5'd10, 32'h00000011, 1, 5'd11, 32'hFFFFFFFF);
    step();
    wr(0, 0, 0, 0, 0, 0);
    rd(5'd10, 5'd11);
    chk("dual_p0", bus.readData[31:0], 32'h00000011);
    chk("dual_p1", bus.readData[63:32], 32'hFFFFFFFF);

    // Zero register, including the same-cycle read.
    wr(1, 5'd0, 32'hDEADBEEF, 1, 5'd0, 32'hDEADBEEF);
    rd(5'd0, 5'd0);
    chk("zero_same_cycle", bus.readData[31:0], 32'd0);
    step();
    wr(0, 0, 0, 0, 0, 0);
    rd(5'd0, 5'd0);
    chk("zero_reg", bus.readData[31:0], 32'd0);
    chk("zero_reg_p1", bus.readData[63:32], 32'd0);

    // Same-cycle forwarding (or its absence).
`ifdef RF_BYPASS_EN
    byp_exp = 32'h0BADF00D;
`else
    byp_exp = 32'd0;
`endif
    wr(1, 5'd9, 32'h0BADF00D, 0, 0, 0);
    rd(5'd9, 5'd2);
    chk("bypass_same_cycle", bus.readData[31:0], byp_exp);
    step();
    wr(0, 0, 0, 0, 0, 0);
    rd(5'd9, 5'd9);
    chk("bypass_after_edge", bus.readData[31:0], 32'h0BADF00D);

`ifdef RF_BYPASS_EN
    byp_exp = 32'h22222222;
`else
    byp_exp = 32'd0;
`endif
    wr(1, 5'd12, 32'h11111111, 1, 5'd12, 32'h22222222);
    rd(5'd2, 5'd12);
    chk("bypass_prio", bus.readData[63:32], byp_exp);
    step();
    wr(0, 0, 0, 0, 0, 0);
    rd(5'd12, 5'd12);
    chk("prio_stored", bus.readData[63:32], 32'h22222222);

    // Reset in RUN gates outputs immediately and restarts the clear.
    rd(5'd2, 5'd2);
    rst = 1'b1;
    #1;
    chk("run_rst_ready", {31'd0, bus.ready}, 32'd0);
    chk("run_rst_rd", bus.readData[31:0], 32'd0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("midclr_ready", {31'd0, bus.ready}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_seq("restart");
    rd(5'd2, 5'd12);
    chk("reclear_reg2", bus.readData[31:0], 32'd0);
    chk("reclear_reg12", bus.readData[63:32], 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
